// File: rtl/nand_pass_sched_if.sv
// rtl/nand_pass_sched_if.sv - client-side request/result bundle for nand_pass_sched
interface nand_pass_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] a_in;
    logic [WIDTH*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   done;
    logic [WIDTH-1:0]       result;
    logic [2:0]             result_id;
    logic                   busy;

    modport master (
        output req, op, a_in, b_in,
        input  gnt, done, result, result_id, busy
    );

    modport slave (
        input  req, op, a_in, b_in,
        output gnt, done, result, result_id, busy
    );
endinterface

// File: rtl/nand_pass_sched.sv
// rtl/nand_pass_sched.sv - round-robin scheduler sharing one NAND evaluator across requesters
// Optional NAND_PASS_CNT_EN adds a saturating 16-bit pass_count output.
module nand_pass_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    nand_pass_sched_if.slave bus
`ifdef NAND_PASS_CNT_EN
    ,
    output logic [15:0]      pass_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, res_q, res_d;
    logic [1:0]       op_q, op_d, cnt_q, cnt_d;
    logic [2:0]       id_q, id_d, ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             done_q, done_d;

    logic             any_req;
    logic [2:0]       pick;
    logic [WIDTH-1:0] a_sel, b_sel, opa, opb, nand_o;
    logic [1:0]       op_sel;
    logic             last;

    // First requester at or after the pointer; iterating downward lets the nearest one win.
    always_comb begin : arb
        int j;
        j       = 0;
        any_req = 1'b0;
        pick    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % N_REQ;
            if (bus.req[j]) begin
                any_req = 1'b1;
                pick    = 3'(j);
            end
        end
    end

    assign a_sel  = bus.a_in[int'(pick)*WIDTH +: WIDTH];
    assign b_sel  = bus.b_in[int'(pick)*WIDTH +: WIDTH];
    assign op_sel = bus.op[int'(pick)*2 +: 2];

    // Pass count for an op is op+1, so the final pass is the one where cnt equals op.
    always_comb begin
        opa = x_q;
        opb = x_q;
        unique case (cnt_q)
            2'd0: begin
                opa = a_q;
                opb = op_q[1] ? a_q : b_q;
            end
            2'd1: begin
                opa = op_q[1] ? b_q : x_q;
                opb = op_q[1] ? b_q : x_q;
            end
            2'd2: begin
                opa = x_q;
                opb = y_q;
            end
            default: begin
                opa = x_q;
                opb = x_q;
            end
        endcase
    end

    assign nand_o = ~(opa & opb);
    assign last   = (cnt_q == op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_EVAL;
            S_EVAL:  if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != S_IDLE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        gnt_d  = '0;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    a_d   = a_sel;
                    b_d   = b_sel;
                    op_d  = op_sel;
                    id_d  = pick;
                    cnt_d = 2'd0;
                    gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                end
            end
            S_EVAL: begin
                cnt_d = cnt_q + 2'd1;
                // OR/NOR park the inverted B in y; every other pass writes x.
                if (cnt_q == 2'd1 && op_q[1]) y_d = nand_o;
                else                          x_d = nand_o;
                if (last) begin
                    res_d  = nand_o;
                    done_d = 1'b1;
                end
            end
            S_DONE: begin
                ptr_d = (int'(id_q) == N_REQ - 1) ? 3'd0 : id_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            gnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.result_id = id_q;

`ifdef NAND_PASS_CNT_EN
    logic [15:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_EVAL && pc_q != 16'hFFFF) pc_d = pc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pass_count = pc_q;
`endif
endmodule
